xnode_cfg_loader: RTL and testbench
===================================

# xnode_cfg_loader

Configuration loader for an X-node routing matrix of V vertical by H horizontal tracks. It accepts a stream of W-bit configuration words over a valid/ready handshake and assembles them in a shadow register. It then commits the assembled image atomically to the V*H-bit `prog` bus that drives the matrix's per-crosspoint programming inputs. The block sits between the bitstream source and the routing fabric; the fabric never sees a partially loaded image.

## Interface
- `V`, 4, vertical tracks per matrix.
- `H`, 4, horizontal tracks per matrix.
- `W`, 8, configuration word width; NW = ceil(V*H/W) words per image.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin loading a new image; honoured only in IDLE.
- `abort`  in  1  discard the image in progress and return to IDLE; `prog` is unchanged.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_data`  in  W  configuration word.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `prog`  out  V*H  committed crosspoint programming bits; bit layout matches the matrix (row x = `prog[V*H-1-V*x -: V]`).
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a new image is committed.
- `err`  out  1  sticky parity failure flag; cleared by the next accepted `start`.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), COMMIT.
- IDLE: `cfg_ready`=0. `start`=1 with `abort`=0 clears the word counter and `err`, then goes to LOAD.
- LOAD: `cfg_ready`=1. A transfer occurs when `cfg_valid`&&`cfg_ready`.
  - On each transfer the shadow register (NW*W bits) shifts left by W and the word enters at the LSBs. The counter increments.
  - On the transfer of word NW-1 (counting from 0), the next state is CHECK with the macro defined, otherwise COMMIT.
- Image mapping: the first word's MSB lands at `prog[V*H-1]`. `prog` is taken from `shadow[NW*W-1 -: V*H]`. The low NW*W-V*H bits are padding and are ignored.
- COMMIT: `prog` <= shadow image, `done` <= 1 for one cycle, then next state is IDLE. `cfg_ready`=0.
- `abort` in any state returns to IDLE on the next edge. `prog` is untouched and `err` is unchanged. If `abort` and the last transfer occur in the same cycle, `abort` wins and there is no commit.
- `start` in any state other than IDLE is ignored.
- Data presented while `cfg_ready`=0 is not consumed.
- Reset mid-load: all state is cleared immediately and `prog` returns to 0. With every `prog` bit at 0, every crosspoint is a straight pass-through.

## Timing
- Reset values: `prog`=0, `cfg_ready`=0, `busy`=0, `done`=0, `err`=0, state=IDLE.
- `start` is sampled at edge t0. `cfg_ready`=1 from t0 onward.
- With a continuously valid source the loader accepts one word per cycle, with no bubbles.
- The last data word is accepted at edge tL (or the parity word, with the macro). COMMIT holds from tL. `prog` updates and `done`=1 at edge tL+1, and `busy` falls at the same edge.
- Minimum image time is NW+1 cycles after `start` (NW+2 with the macro).
- `done` is never high for two consecutive cycles.
- `cfg_ready` is a registered function of state only; it does not depend combinationally on `cfg_valid`.

## Configuration
- `XCFG_PARITY_EN` defined:
  - After the NW data words, CHECK expects one extra word with `cfg_ready`=1.
  - Its bit 0 must equal the XOR of all NW*W received data bits, padding included. The remaining bits are ignored.
  - Match: go to COMMIT.
  - Mismatch: set `err`=1 and go to IDLE with no commit; `prog` is unchanged.
- Not defined: the CHECK state and the parity logic are absent, `err` is tied to 0, and LOAD goes directly to COMMIT.

## Test plan
- Reset and pass-through: assert `rst_n`=0 mid-LOAD → all outputs 0 on the same cycle. After release, state is IDLE.
- Basic load (V=4, H=3, W=5, NW=3, macro off): `start`, then words 10101, 01100, 11111 back-to-back → `prog`=0xAB3 one cycle after the third accept, with a single `done` pulse.
- Backpressure/gaps: the same words with `cfg_valid` toggling 1,0,0,1,0,1 → same `prog`=0xAB3. Words are never consumed while `cfg_ready`=0.
- Abort: previous image is 0xAB3. `start`, two words, then `abort` coincident with the third transfer → `prog` stays 0xAB3, `done` never pulses, `busy`=0 next cycle.
- Parity (macro on): the same three words plus parity word 00000 → commit to 0xAB3. Repeat with 00001 → `err`=1 with no commit. A following `start` clears `err`.
- Ignored start: pulse `start` during LOAD → word counter not reset. The image completes after exactly NW transfers.

Source files
------------

// File: rtl/xnode_cfg_loader.sv
// xnode_cfg_loader: streams W-bit configuration words into a shadow register
// and commits the assembled V*H-bit crosspoint image to `prog` in one edge,
// so the routing fabric never sees a partially loaded image.
//
// Optional build macro XCFG_PARITY_EN: adds a CHECK state that consumes one
// extra word whose bit 0 must equal the XOR of every received data bit.
// A mismatch sets the sticky `err` flag and drops the image without commit.
module xnode_cfg_loader #(
    parameter int V = 4,
    parameter int H = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_valid,
    input  logic [W-1:0]     cfg_data,
    output logic             cfg_ready,
    output logic [V*H-1:0]   prog,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int NW = (V * H + W - 1) / W;
    localparam int SW = NW * W;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHECK  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   shadow;
    logic            xfer;
    logic            last_word;
    logic            start_ok;

    assign xfer      = cfg_valid && cfg_ready;
    assign last_word = (cnt == CW'(NW - 1));
    assign start_ok  = (state == S_IDLE) && start && !abort;

`ifdef XCFG_PARITY_EN
    logic par;
    logic par_ok;
    assign par_ok = (cfg_data[0] == par);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode; abort overrides every other transition
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (xfer && last_word) begin
`ifdef XCFG_PARITY_EN
                        nxt = S_CHECK;
`else
                        nxt = S_COMMIT;
`endif
                    end
                end
`ifdef XCFG_PARITY_EN
                S_CHECK: begin
                    if (xfer) nxt = par_ok ? S_COMMIT : S_IDLE;
                end
`endif
                S_COMMIT: nxt = S_IDLE;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state register only
    always_comb begin
        cfg_ready = (state == S_LOAD) || (state == S_CHECK);
        busy      = (state != S_IDLE);
    end

    // Word counter and shadow shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (start_ok) begin
            cnt <= '0;
        end else if ((state == S_LOAD) && xfer) begin
            cnt    <= cnt + CW'(1);
            shadow <= (shadow << W) | SW'(cfg_data);
        end
    end

    // Atomic commit of the image and the one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == S_COMMIT) && !abort;
            if ((state == S_COMMIT) && !abort) begin
                prog <= shadow[SW-1 -: V*H];
            end
        end
    end

`ifdef XCFG_PARITY_EN
    // Running parity over data words and the sticky mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
            err <= 1'b0;
        end else if (start_ok) begin
            par <= 1'b0;
            err <= 1'b0;
        end else begin
            if ((state == S_LOAD) && xfer) begin
                par <= par ^ (^cfg_data);
            end
            if ((state == S_CHECK) && xfer && !abort && !par_ok) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xnode_cfg_loader.sv
// Directed bench for xnode_cfg_loader with V=4, H=3, W=5 (three words per image).
module tb_xnode_cfg_loader;

    localparam int V = 4;
    localparam int H = 3;
    localparam int W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [W-1:0]     cfg_data = '0;
    logic             cfg_ready;
    logic [V*H-1:0]   prog;
    logic             busy;
    logic             done;
    logic             err;

    int ncmp = 0;
    int nfail = 0;

    xnode_cfg_loader #(.V(V), .H(H), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .prog      (prog),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        step();
        cfg_valid = 1'b0;
        cfg_data  = '0;
    endtask

    // Full image load with back-to-back words; pw is the parity word when
    // parity is built in, and otherwise is waved at the loader during COMMIT.
    task automatic load_check(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] pw,
                              input logic [V*H-1:0] exp);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_ready_load"}, cfg_ready, 1);
        chk({tag, "_busy_load"}, busy, 1);
        send(w0);
        send(w1);
        send(w2);
`ifdef XCFG_PARITY_EN
        chk({tag, "_ready_check"}, cfg_ready, 1);
        send(pw);
`endif
        chk({tag, "_ready_commit"}, cfg_ready, 0);
        chk({tag, "_done_early"}, done, 0);
        chk({tag, "_busy_commit"}, busy, 1);
        cfg_valid = 1'b1;
        cfg_data  = pw;
        step();
        cfg_valid = 1'b0;
        cfg_data  = '0;
        chk({tag, "_prog"}, prog, exp);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        step();
        chk({tag, "_done_once"}, done, 0);
        chk({tag, "_prog_hold"}, prog, exp);
    endtask

    initial begin
        // Power-on reset
        step();
        step();
        chk("rst_prog", prog, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", cfg_ready, 0);
        chk("idle_busy", busy, 0);

        // Basic load: 10101 01100 11111 -> 0xAB3, parity of 15 bits is 0
        load_check("basic", 5'b10101, 5'b01100, 5'b11111, 5'b00000, 12'hAB3);

        // Valid data in IDLE must not be consumed
        cfg_valid = 1'b1;
        cfg_data  = 5'b11111;
        step();
        step();
        chk("idle_noconsume_ready", cfg_ready, 0);
        chk("idle_noconsume_prog", prog, 12'hAB3);
        cfg_valid = 1'b0;
        cfg_data  = '0;

        // Second image: 00000 11111 00000 -> 0x07C, parity 1
        load_check("img2", 5'b00000, 5'b11111, 5'b00000, 5'b00001, 12'h07C);

        // Gapped source: valid pattern 1,0,0,1,0,1
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'b10101);
        cfg_data = 5'b11111;
        step();
        step();
        chk("gap_ready_mid", cfg_ready, 1);
        send(5'b01100);
        cfg_data = 5'b00011;
        step();
        cfg_data = '0;
        chk("gap_still_load", cfg_ready, 1);
        send(5'b11111);
`ifdef XCFG_PARITY_EN
        send(5'b00000);
`endif
        chk("gap_commit_ready", cfg_ready, 0);
        step();
        chk("gap_prog", prog, 12'hAB3);
        chk("gap_done", done, 1);
        step();
        chk("gap_done_once", done, 0);

        // Abort coincident with the final data transfer
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'b10101);
        send(5'b01100);
        abort     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 5'b11111;
        step();
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", cfg_ready, 0);
        chk("abort_done", done, 0);
        step();
        chk("abort_done_next", done, 0);
        chk("abort_prog", prog, 12'hAB3);

        // Start pulsed during LOAD must not restart the word count
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'b00000);
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'b11111);
        send(5'b00000);
`ifdef XCFG_PARITY_EN
        send(5'b00001);
`endif
        chk("ign_start_commit_ready", cfg_ready, 0);
        chk("ign_start_commit_busy", busy, 1);
        step();
        chk("ign_start_prog", prog, 12'h07C);
        chk("ign_start_done", done, 1);
        step();

`ifdef XCFG_PARITY_EN
        // Parity mismatch: AB3 words need parity 0, send 1
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'b10101);
        send(5'b01100);
        send(5'b11111);
        send(5'b00001);
        chk("par_err", err, 1);
        chk("par_busy", busy, 0);
        chk("par_done", done, 0);
        step();
        chk("par_prog_kept", prog, 12'h07C);
        chk("par_done_next", done, 0);
        chk("par_err_sticky", err, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("par_err_cleared", err, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("par_abort_idle", busy, 0);
`endif

        // Asynchronous reset in the middle of a load
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'b10101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_prog", prog, 0);
        chk("midrst_ready", cfg_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("postrst_busy", busy, 0);
        chk("postrst_ready", cfg_ready, 0);
        load_check("postrst", 5'b10101, 5'b01100, 5'b11111, 5'b00000, 12'hAB3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
